// File: rtl/sfifo_pkg.sv
// sfifo_pkg
//   Shared definitions for the single-clock FIFO:
//   - default parameter values for sfifo
//   - cnt_width(): width of pointers and fill count (one extra bit so a
//     completely full FIFO is distinguishable from an empty one)
//   - sfifo_flags_t: bundle of the status decodes produced from the count
package sfifo_pkg;

    localparam int DSIZE_DEF     = 8;
    localparam int ASIZE_DEF     = 4;
    localparam int FWFT_DEF      = 0;
    localparam int AFULL_TH_DEF  = 12;
    localparam int AEMPTY_TH_DEF = 2;

    // Pointers and count carry ASIZE+1 bits: count ranges 0..2**ASIZE.
    function automatic int cnt_width(input int asize);
        return asize + 1;
    endfunction

    typedef struct packed {
        logic wfull;
        logic afull;
        logic rempty;
        logic aempty;
    } sfifo_flags_t;

endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem
//   DEPTH x DSIZE storage for sfifo. Synchronous write port, asynchronous
//   (combinational) read port. Contents are not reset.
// Ports:
//   i_clk    : clock, write happens on the rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : word at i_raddr (combinational)
module sfifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sfifo.sv
// sfifo
//   Single-clock synchronous FIFO with fill count, almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags, synchronous flush and a
//   selectable read mode (registered read or first-word-fall-through).
// Ports:
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_wr       : write request          i_wdata : write data
//   i_rd       : read request / FWFT pop of the displayed head word
//   o_rdata    : read data
//   o_wfull    : count == DEPTH         o_afull  : count >= AFULL_TH
//   o_rempty   : count == 0             o_aempty : count <= AEMPTY_TH
//   o_count    : fill level 0..DEPTH
//   i_flush    : synchronous clear of contents (pointers/count)
//   i_clr_err  : clears o_ovf/o_udf
//   o_ovf      : sticky, write attempted while full
//   o_udf      : sticky, read attempted while empty
module sfifo
    import sfifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ASIZE     = ASIZE_DEF,
    parameter int FWFT      = FWFT_DEF,
    parameter int AFULL_TH  = AFULL_TH_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr,
    input  logic [DSIZE-1:0]            i_wdata,
    input  logic                        i_rd,
    output logic [DSIZE-1:0]            o_rdata,
    output logic                        o_wfull,
    output logic                        o_afull,
    output logic                        o_rempty,
    output logic                        o_aempty,
    output logic [cnt_width(ASIZE)-1:0] o_count,
    input  logic                        i_flush,
    input  logic                        i_clr_err,
    output logic                        o_ovf,
    output logic                        o_udf
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int CW    = cnt_width(ASIZE);

    generate
        if (ASIZE < 1 || AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_param
            $fatal(1, "sfifo: illegal parameters (need ASIZE>=1, 0<=AEMPTY_TH<AFULL_TH<=DEPTH)");
        end
    endgenerate

    logic [CW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic             wr_rej, rd_rej;
    logic             mem_we;
    logic [DSIZE-1:0] mem_rdata;
    sfifo_flags_t     flags;

    // Status decodes look only at the registered count, so there is no
    // combinational path from any input to a flag.
    always_comb begin
        flags.wfull  = (count_q == CW'(DEPTH));
        flags.afull  = (count_q >= CW'(AFULL_TH));
        flags.rempty = (count_q == '0);
        flags.aempty = (count_q <= CW'(AEMPTY_TH));
    end

    assign o_wfull  = flags.wfull;
    assign o_afull  = flags.afull;
    assign o_rempty = flags.rempty;
    assign o_aempty = flags.aempty;
    assign o_count  = count_q;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;

    // Flush masks both requests: nothing is stored or popped and no error
    // is raised in that cycle.
    always_comb begin
        wr_acc = i_wr & ~flags.wfull  & ~i_flush;
        rd_acc = i_rd & ~flags.rempty & ~i_flush;
        wr_rej = i_wr &  flags.wfull  & ~i_flush;
        rd_rej = i_rd &  flags.rempty & ~i_flush;
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + CW'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + CW'(1);
            end
        end
        // The extra pointer bit makes the modular difference exact over
        // 0..DEPTH, so the count follows the pointers without its own
        // increment/decrement bookkeeping.
        count_d = wptr_d - rptr_d;
        // A fresh error in the same cycle as a clear keeps the flag set.
        ovf_d = wr_rej | (ovf_q & ~i_clr_err);
        udf_d = rd_rej | (udf_q & ~i_clr_err);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // The storage has no reset; block writes while reset is held so no word
    // lands in the array from a request overlapping reset.
    assign mem_we = wr_acc & i_rst_n;

    sfifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wptr_q[ASIZE-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (rptr_q[ASIZE-1:0]),
        .o_rdata (mem_rdata)
    );

    generate
        if (FWFT == 0) begin : g_reg_read
            // Head word is captured on the popping edge and held until the
            // next accepted read.
            logic [DSIZE-1:0] rdata_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem_rdata;
                end
            end

            assign o_rdata = rdata_q;
        end else begin : g_fwft
            // Head word is always on the output; only meaningful when not empty.
            assign o_rdata = mem_rdata;
        end
    endgenerate

endmodule

// File: doc/sfifo.md
Name: sfifo

Overview:
Single-clock, parametrised synchronous FIFO. It is the successor to the dual-clock FIFO core, for designs where producer and consumer share one clock. It adds configurable width and depth, almost-full/almost-empty thresholds, a fill-level count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between on-chip data sources/sinks and the TT pin wrapper.

Parameters:
DSIZE, 8, data word width in bits.
ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
FWFT, 0, read mode: 0 = registered read (data one cycle after pop), 1 = first-word-fall-through.
AFULL_TH, 12, o_afull asserted when count >= AFULL_TH.
AEMPTY_TH, 2, o_aempty asserted when count <= AEMPTY_TH.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_wr  input  1  write request
i_wdata  input  DSIZE  write data
i_rd  input  1  read request (FWFT: pop/acknowledge of head word)
o_rdata  output  DSIZE  read data
o_wfull  output  1  count == DEPTH
o_afull  output  1  count >= AFULL_TH
o_rempty  output  1  count == 0
o_aempty  output  1  count <= AEMPTY_TH
o_count  output  ASIZE+1  current fill level, 0..DEPTH
i_flush  input  1  synchronous clear of FIFO contents
i_clr_err  input  1  clears o_ovf/o_udf
o_ovf  output  1  sticky: write attempted while full
o_udf  output  1  sticky: read attempted while empty

Behaviour:
- Reset (i_rst_n low, async assert): write/read pointers = 0, count = 0, o_rdata = 0, o_ovf = o_udf = 0. Flags follow: o_rempty = 1, o_aempty = 1, o_wfull = 0, o_afull = 0. Storage array is not reset.
- Pointers are ASIZE+1 bits and wrap naturally modulo 2*DEPTH. Array address = low ASIZE bits.
- Write accepted iff i_wr & ~o_wfull. Data is stored at wptr and wptr increments.
- Read accepted iff i_rd & ~o_rempty. rptr increments.
- Count: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither are accepted.
- All flags are combinational decodes of the registered count (no comb path from inputs to flags).
- Full + i_wr + i_rd in the same cycle: the write is rejected and o_ovf sets; the read is accepted; count ends at DEPTH-1.
- Empty + i_wr + i_rd in the same cycle: the read is rejected and o_udf sets; the write is accepted; count ends at 1.
- Rejected write: data dropped, no state change except o_ovf <= 1. Rejected read: no state change except o_udf <= 1. o_rdata holds.
- i_clr_err clears both sticky flags on the next edge. A new error in the same cycle wins (flag stays 1).
- FWFT=0: o_rdata is registered. It loads mem[rptr] on the edge of an accepted read, so data is valid the cycle after the pop. It holds otherwise.
- FWFT=1: o_rdata = mem[rptr] whenever o_rempty = 0 (async array read). It is undefined but stable while empty. A write into an empty FIFO makes the word visible in the cycle after the write edge. i_rd consumes the displayed word.
- i_flush (synchronous): on the next edge, pointers = 0 and count = 0. i_wr and i_rd are ignored that cycle and raise no errors. o_ovf/o_udf are unaffected. In FWFT=0, o_rdata holds.
- Async reset mid-operation: immediate return to reset values. No partial write is committed after release.
- Elaboration check: 0 <= AEMPTY_TH < AFULL_TH <= DEPTH, ASIZE >= 1. Violation is a fatal error.

Decomposition:
- Package sfifo_pkg: default parameter constants, and a count-width function (ASIZE+1).
- Sub-module sfifo_mem: DEPTH x DSIZE register array, synchronous write port, asynchronous read port.
- Pointer/count/flag control stays in sfifo.

Test Plan:
- Reset, then idle: o_rempty = 1, o_aempty = 1, o_wfull = 0, o_count = 0, o_rdata = 0, o_ovf = o_udf = 0.
- FWFT=0: write 0x01..0x10 (16 words): o_afull rises when count = 12, o_wfull when count = 16. Read 16 words: o_rdata = 0x01..0x10, each one cycle after its pop. o_rempty = 1 at the end.
- Fill to 16, then i_wr & i_rd together with data 0xAA: o_ovf = 1, count = 15, 0xAA is not stored. i_clr_err then gives o_ovf = 0.
- Empty, i_rd & i_wr together with 0x5C: o_udf = 1, count = 1. With FWFT=1, o_rdata = 0x5C the next cycle with no pop.
- Wrap: 40 interleaved write/read pairs at count ~8. Data order is preserved across pointer wrap and o_count stays constant.
- Count 7, assert i_flush with i_wr = 1: count = 0, o_rempty = 1, no word written, sticky flags unchanged. Async reset mid-burst returns all outputs to reset values.
